vlane_array: RTL and testbench

Parametrised, pipelined successor to the fixed four-lane 16-bit vector ALU. It applies one vector-scalar operation across `LANES` elements of `EW` bits, either whole or split into two half-width sub-elements. It adds a valid/ready handshake, a registered result and a multi-cycle sequential reduction (REDSUM). It sits between the vector register file read port and the writeback stage of the vector datapath.

---
 rtl/vlane_pkg.sv | 23 ++
 rtl/vlane_elem.sv | 88 ++++++++
 rtl/vlane_array.sv | 145 ++++++++++++++
 tb/tb_vlane_array.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vlane_pkg.sv
// Shared types for the vector lane array: op encoding and FSM states.
// Saturating arithmetic is selected by the VLANE_SAT_EN macro in the modules.
package vlane_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_SLL    = 3'b011,
    OP_INC1   = 3'b100,
    OP_REDSUM = 3'b101,
    OP_RSV6   = 3'b110,
    OP_RSV7   = 3'b111
  } vlane_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    REDUCE = 1'b1
  } vlane_state_e;

endpackage

// File: rtl/vlane_elem.sv
// Combinational single-element ALU, full width or two independent half-width lanes.
// Defining VLANE_SAT_EN switches ADD/INC1 to unsigned saturation and SUB to clamp-at-zero.
module vlane_elem
  import vlane_pkg::*;
#(
  parameter int EW = 16
) (
  input  vlane_op_e       op,
  input  logic            size,
  input  logic [EW-1:0]   elem,
  input  logic [EW-1:0]   srcb,
  input  logic [1:0]      inc_sel,
  output logic [EW-1:0]   res
);

  localparam int H   = EW / 2;
  localparam int SHW = $clog2(EW);

  function automatic logic [EW-1:0] add_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef VLANE_SAT_EN
    logic [EW:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[EW] ? '1 : t[EW-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [EW-1:0] sub_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef VLANE_SAT_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  function automatic logic [H-1:0] add_h(input logic [H-1:0] a, input logic [H-1:0] b);
`ifdef VLANE_SAT_EN
    logic [H:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[H] ? '1 : t[H-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [H-1:0] sub_h(input logic [H-1:0] a, input logic [H-1:0] b);
`ifdef VLANE_SAT_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  logic [H-1:0]   lo, hi, sh;
  logic [SHW-1:0] amt;

  assign lo  = elem[H-1:0];
  assign hi  = elem[EW-1:H];
  assign sh  = srcb[H-1:0];
  assign amt = srcb[SHW-1:0];

  always_comb begin
    res = elem;
    if (!size) begin
      case (op)
        OP_ADD:  res = add_f(elem, srcb);
        OP_SUB:  res = sub_f(elem, srcb);
        OP_XOR:  res = elem ^ srcb;
        OP_SLL:  res = elem << amt;
        OP_INC1: res = inc_sel[0] ? add_f(elem, srcb) : elem;
        default: res = elem;
      endcase
    end else begin
      case (op)
        OP_ADD:  res = {add_h(hi, sh), add_h(lo, sh)};
        OP_SUB:  res = {sub_h(hi, sh), sub_h(lo, sh)};
        OP_XOR:  res = {hi ^ sh, lo ^ sh};
        // Each half shifts on its own; amounts past the half width flush to zero.
        OP_SLL:  res = (amt >= SHW'(H)) ? '0 : {H'(hi << amt), H'(lo << amt)};
        OP_INC1: res = {inc_sel[1] ? add_h(hi, sh) : hi,
                        inc_sel[0] ? add_h(lo, sh) : lo};
        default: res = elem;
      endcase
    end
  end

endmodule

// File: rtl/vlane_array.sv
// Pipelined vector-scalar ALU over LANES elements with registered output and
// sequential REDSUM reduction; VLANE_SAT_EN selects saturating arithmetic.
module vlane_array
  import vlane_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 16,
  parameter int IDXW  = $clog2(LANES) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic                  size,
  input  logic [LANES*EW-1:0]   rv,
  input  logic [EW-1:0]         srcb,
  input  logic [IDXW-1:0]       idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*EW-1:0]   res,
  output logic                  busy
);

  localparam int H  = EW / 2;
  localparam int CW = $clog2(LANES);

  function automatic logic [EW-1:0] acc_add_f(input logic [EW-1:0] a, input logic [EW-1:0] b);
`ifdef VLANE_SAT_EN
    logic [EW:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[EW] ? '1 : t[EW-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic [H-1:0] acc_add_h(input logic [H-1:0] a, input logic [H-1:0] b);
`ifdef VLANE_SAT_EN
    logic [H:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[H] ? '1 : t[H-1:0];
`else
    return a + b;
`endif
  endfunction

  vlane_op_e     op_e;
  vlane_state_e  state, state_nxt;
  logic          fire, red_fire, red_last;
  logic [IDXW-1:0]      cnt;
  logic [EW-1:0]        acc, acc_nxt, red_elem;
  logic [EW-1:0]        rv_p1 [LANES];
  logic                 size_p1;
  logic [LANES*EW-1:0]  ew_res, red_res;

  assign op_e     = vlane_op_e'(op);
  assign fire     = in_valid && in_ready;
  assign red_fire = fire && (op_e == OP_REDSUM);
  assign red_last = (state == REDUCE) && (cnt == IDXW'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (red_fire) state_nxt = REDUCE;
      REDUCE:  if (red_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == REDUCE);
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  // Stage p0: element-wise lanes straight from the request inputs
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [1:0] sel;
    always_comb begin
      if (size) sel = {idx == IDXW'(2*k + 1), idx == IDXW'(2*k)};
      else      sel = {1'b0, idx[IDXW-2:0] == (IDXW-1)'(k)};
    end
    vlane_elem #(.EW(EW)) u_elem (
      .op      (op_e),
      .size    (size),
      .elem    (rv[k*EW +: EW]),
      .srcb    (srcb),
      .inc_sel (sel),
      .res     (ew_res[k*EW +: EW])
    );
  end

  // Stage p1: reduction operand latch, sampled only on an accepted REDSUM
  always_ff @(posedge clk) begin
    if (red_fire) begin
      for (int k = 0; k < LANES; k++) rv_p1[k] <= rv[k*EW +: EW];
      size_p1 <= size;
    end
  end

  assign red_elem = rv_p1[cnt[CW-1:0]];

  // Half mode keeps separate low/high sub-element sums, folded together on the last add.
  always_comb begin
    if (size_p1) acc_nxt = {acc_add_h(acc[EW-1:H], red_elem[EW-1:H]),
                            acc_add_h(acc[H-1:0],  red_elem[H-1:0])};
    else         acc_nxt = acc_add_f(acc, red_elem);
    red_res = '0;
    if (size_p1) red_res[H-1:0]  = acc_add_h(acc_nxt[H-1:0], acc_nxt[EW-1:H]);
    else         red_res[EW-1:0] = acc_nxt;
  end

  // Stage p2: output register and reduction state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (red_fire) begin
        cnt <= '0;
        acc <= '0;
      end else if (state == REDUCE) begin
        cnt <= cnt + IDXW'(1);
        acc <= acc_nxt;
      end
      if (fire && !red_fire) begin
        res       <= ew_res;
        out_valid <= 1'b1;
      end else if (red_last) begin
        res       <= red_res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vlane_array.sv
// Scoreboard bench for vlane_array (LANES=4, EW=16); expectations follow VLANE_SAT_EN.
module tb_vlane_array;
  import vlane_pkg::*;

`ifdef VLANE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, size, out_valid, out_ready, busy;
  logic [2:0]  op, idx;
  logic [63:0] rv, res;
  logic [15:0] srcb;

  typedef struct { logic [63:0] v; int id; } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   next_id = 0;

  always #5 clk = ~clk;

  vlane_array #(.LANES(4), .EW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .size(size), .rv(rv), .srcb(srcb), .idx(idx),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request, wait for the accept edge, queue the expected result.
  task automatic send(input logic [2:0] o, input logic s, input logic [63:0] v,
                      input logic [15:0] b, input logic [2:0] i,
                      input logic [63:0] want, input bit push);
    int n = 0;
    op = o; size = s; rv = v; srcb = b; idx = i; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready_low want=accept op=%0d", o);
    end else if (push) begin
      exp_q.push_back('{v: want, id: next_id});
      next_id++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got=%h want=no_output", res);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res !== e.v) begin
          bad++;
          $display("FAIL result_%0d got=%h want=%h", e.id, res, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; size = 1'b0; rv = '0;
    srcb = '0; idx = '0; out_ready = 1'b1;
    idle(2);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy",      {63'b0, busy},      64'd0);
    chk("rst_res",       res,                64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    idle(1);

    send(OP_ADD, 1'b0, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h0010, 3'd0,
         {16'h0014, 16'h0013, 16'h0012, 16'h0011}, 1'b1);
    chk("add_latency", {63'b0, out_valid}, 64'd1);
    send(OP_ADD, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 16'h0002, 3'd0,
         {16'h0002, 16'h0002, 16'h0002, SAT ? 16'hFFFF : 16'h0001}, 1'b1);
    send(OP_ADD, 1'b1, {16'h0000, 16'h0000, 16'h0000, 16'h01FF}, 16'h0001, 3'd0,
         {16'h0101, 16'h0101, 16'h0101, SAT ? 16'h02FF : 16'h0200}, 1'b1);
    send(OP_SUB, 1'b0, {16'h0005, 16'h0010, 16'h0000, 16'h0100}, 16'h0003, 3'd0,
         {16'h0002, 16'h000D, SAT ? 16'h0000 : 16'hFFFD, 16'h00FD}, 1'b1);
    send(OP_XOR, 1'b0, {16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000}, 16'h0F0F, 3'd0,
         {16'hA5A5, 16'h5A5A, 16'hF0F0, 16'h0F0F}, 1'b1);
    send(OP_SLL, 1'b0, {16'h8001, 16'h0001, 16'h00FF, 16'h1234}, 16'h0004, 3'd0,
         {16'h0010, 16'h0010, 16'h0FF0, 16'h2340}, 1'b1);
    send(OP_SLL, 1'b1, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 16'h0008, 3'd0,
         64'd0, 1'b1);
    send(OP_SLL, 1'b1, {16'h0000, 16'h0000, 16'h00FF, 16'h0181}, 16'h0003, 3'd0,
         {16'h0000, 16'h0000, 16'h00F8, 16'h0808}, 1'b1);
    send(OP_INC1, 1'b0, {4{16'h0010}}, 16'h0005, 3'b110,
         {16'h0010, 16'h0015, 16'h0010, 16'h0010}, 1'b1);
    send(OP_INC1, 1'b1, {4{16'h1010}}, 16'h0105, 3'd5,
         {16'h1010, 16'h1510, 16'h1010, 16'h1010}, 1'b1);
    send(OP_RSV6, 1'b0, {16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567}, 16'hFFFF, 3'd1,
         {16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567}, 1'b1);

    // REDSUM timing: busy for four cycles, result on the fifth
    idle(2);
    send(OP_REDSUM, 1'b0, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h0000, 3'd0,
         64'h000A, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("red_busy_t%0d", c),     {63'b0, busy},      64'd1);
      chk($sformatf("red_in_ready_t%0d", c), {63'b0, in_ready},  64'd0);
      chk($sformatf("red_out_valid_t%0d", c),{63'b0, out_valid}, 64'd0);
      idle(1);
    end
    chk("red_done_valid", {63'b0, out_valid}, 64'd1);
    chk("red_done_busy",  {63'b0, busy},      64'd0);
    send(OP_REDSUM, 1'b0, {16'hFFFF, 16'h0002, 16'h0001, 16'h0000}, 16'h0000, 3'd0,
         SAT ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_0000_0002, 1'b1);
    send(OP_REDSUM, 1'b1, {16'h0102, 16'h0304, 16'h0506, 16'h0708}, 16'h0000, 3'd0,
         64'h0024, 1'b1);
    send(OP_REDSUM, 1'b1, {16'h0000, 16'h0000, 16'h0001, 16'h80FF}, 16'h0000, 3'd0,
         SAT ? 64'h00FF : 64'h0080, 1'b1);

    // Backpressure with a queued request behind the stalled result
    idle(8);
    out_ready = 1'b0;
    send(OP_ADD, 1'b0, {4{16'h0001}}, 16'h0001, 3'd0, {4{16'h0002}}, 1'b1);
    op = OP_XOR; size = 1'b0; rv = {4{16'h00FF}}; srcb = 16'hFFFF; idx = '0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_valid_%0d", c), {63'b0, out_valid}, 64'd1);
      chk($sformatf("bp_ready_%0d", c), {63'b0, in_ready},  64'd0);
      chk($sformatf("bp_hold_%0d", c),  res, {4{16'h0002}});
      idle(1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_rise", {63'b0, in_ready}, 64'd1);
    exp_q.push_back('{v: {4{16'hFF00}}, id: next_id});
    next_id++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_valid", {63'b0, out_valid}, 64'd1);

    // Reset in the middle of a reduction discards it
    idle(3);
    send(OP_REDSUM, 1'b0, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'h0000, 3'd0,
         64'h000A, 1'b0);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {63'b0, busy},      64'd0);
    chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    idle(1);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      idle(1);
      chk($sformatf("mid_rst_quiet_%0d", c), {63'b0, out_valid}, 64'd0);
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
